// File: rtl/lsu_mmio_ctrl.sv
// MEM-stage load/store unit: data-memory handshake with timeout, sub-word lanes,
// synchronised input ports and byte-maskable output port registers.
module lsu_mmio_ctrl #(
  parameter int          DMEM_AW  = 8,
  parameter int          N_IN     = 2,
  parameter int          N_OUT    = 4,
  parameter logic [31:0] IN_BASE  = 32'h400,
  parameter logic [31:0] OUT_BASE = 32'h500,
  parameter int          MAX_WAIT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_load,
  input  logic                 i_store,
  input  logic [1:0]           i_size,
  input  logic                 i_signed,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [4:0]           i_rd_addr,
  input  logic                 i_flush,
  output logic                 o_stall,
  output logic                 o_wb_valid,
  output logic                 o_wb_wren,
  output logic [4:0]           o_wb_rd_addr,
  output logic [31:0]          o_wb_data,
  output logic                 o_exc_misalign,
  output logic                 o_exc_bus,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic [DMEM_AW-1:0]   o_dmem_addr,
  output logic [3:0]           o_dmem_be,
  output logic [31:0]          o_dmem_wdata,
  input  logic                 i_dmem_ack,
  input  logic [31:0]          i_dmem_rdata,
  input  logic [32*N_IN-1:0]   i_in_port,
  output logic [32*N_OUT-1:0]  o_out_port,
  output logic [1:0]           o_fsm_state
);

  // Handshake: a request transfers on a clock edge where i_req_valid and
  // o_req_ready are both high; the request fields must be stable in that cycle.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEM = 2'd1, S_RESP = 2'd2} state_t;
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t         state_q, state_d;
  logic [31:0]    h_addr, h_wdata, h_rdata;
  logic [1:0]     h_size;
  logic [4:0]     h_rd;
  logic           h_signed, h_store, h_load, h_bus, h_flush;
  logic [CW-1:0]  wait_q;
  logic [31:0]    in_meta [N_IN];
  logic [31:0]    in_sync [N_IN];
  logic [31:0]    out_q   [N_OUT];

  function automatic logic is_dmem(input logic [31:0] a);
    return (a >> (DMEM_AW + 2)) == 32'd0;
  endfunction

  function automatic logic is_in(input logic [31:0] a);
    return (a[31:8] == IN_BASE[31:8]) && ({1'b0, a[7:4]} < 5'(N_IN));
  endfunction

  function automatic logic is_out(input logic [31:0] a);
    return (a[31:8] == OUT_BASE[31:8]) && ({1'b0, a[7:4]} < 5'(N_OUT));
  endfunction

  function automatic logic misaligned(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
  endfunction

  logic accept, go_mem, timeout, mis_h, out_we;
  logic [3:0]  be_base, be;
  logic [31:0] wdata_sh, raw, shifted, ext;

  assign accept  = i_req_valid && (state_q == S_IDLE) && (i_load || i_store);
  // A store flushed at accept never reaches memory; loads still go out.
  assign go_mem  = is_dmem(i_addr) && !misaligned(i_addr, i_size) && !(i_flush && i_store);
  assign timeout = (wait_q == CW'(MAX_WAIT - 1));
  assign mis_h   = misaligned(h_addr, h_size);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = go_mem ? S_MEM : S_RESP;
      S_MEM:   if (i_dmem_ack || timeout) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      h_addr   <= '0;
      h_wdata  <= '0;
      h_rdata  <= '0;
      h_size   <= '0;
      h_rd     <= '0;
      h_signed <= 1'b0;
      h_store  <= 1'b0;
      h_load   <= 1'b0;
      h_bus    <= 1'b0;
      h_flush  <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          h_flush <= accept && i_flush;
          if (accept) begin
            h_addr   <= i_addr;
            h_wdata  <= i_wdata;
            h_size   <= i_size;
            h_rd     <= i_rd_addr;
            h_signed <= i_signed;
            h_store  <= i_store;
            h_load   <= i_load && !i_store;
            h_rdata  <= '0;
            h_bus    <= 1'b0;
            wait_q   <= '0;
          end
        end
        S_MEM: begin
          wait_q  <= wait_q + CW'(1);
          h_flush <= h_flush || i_flush;
          if (i_dmem_ack) h_rdata <= i_dmem_rdata;
          else if (timeout) h_bus <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (h_size)
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    be       = be_base << h_addr[1:0];
    wdata_sh = h_wdata << {h_addr[1:0], 3'b000};
  end

  always_comb begin
    raw = '0;
    if (is_dmem(h_addr)) begin
      raw = h_rdata;
    end else if (is_in(h_addr)) begin
      for (int k = 0; k < N_IN; k++)
        if (h_addr[7:4] == 4'(k)) raw = in_sync[k];
    end else if (is_out(h_addr)) begin
      for (int k = 0; k < N_OUT; k++)
        if (h_addr[7:4] == 4'(k)) raw = out_q[k];
    end
    shifted = raw >> {h_addr[1:0], 3'b000};
    case (h_size)
      2'b00:   ext = {{24{h_signed & shifted[7]}}, shifted[7:0]};
      2'b01:   ext = {{16{h_signed & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    o_req_ready    = (state_q == S_IDLE);
    o_stall        = (state_q != S_IDLE);
    o_dmem_req     = 1'b0;
    o_dmem_we      = 1'b0;
    o_dmem_addr    = '0;
    o_dmem_be      = '0;
    o_dmem_wdata   = '0;
    o_wb_valid     = 1'b0;
    o_wb_wren      = 1'b0;
    o_wb_rd_addr   = '0;
    o_wb_data      = '0;
    o_exc_misalign = 1'b0;
    o_exc_bus      = 1'b0;
    if (state_q == S_MEM) begin
      o_dmem_req   = 1'b1;
      o_dmem_we    = h_store;
      o_dmem_addr  = h_addr[DMEM_AW+1:2];
      o_dmem_be    = be;
      o_dmem_wdata = wdata_sh;
    end
    if (state_q == S_RESP) begin
      o_wb_valid     = 1'b1;
      o_exc_misalign = mis_h;
      o_exc_bus      = h_bus;
      o_wb_rd_addr   = h_rd;
      o_wb_wren      = h_load && !mis_h && !h_bus && !h_flush && !i_flush;
      if (h_load && !mis_h && !h_bus) o_wb_data = ext;
    end
  end

  assign out_we      = (state_q == S_RESP) && h_store && !mis_h && !h_flush && is_out(h_addr);
  assign o_fsm_state = state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_IN; k++) begin
        in_meta[k] <= '0;
        in_sync[k] <= '0;
      end
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        in_meta[k] <= i_in_port[32*k +: 32];
        in_sync[k] <= in_meta[k];
      end
      if (out_we)
        for (int k = 0; k < N_OUT; k++)
          if (h_addr[7:4] == 4'(k))
            for (int b = 0; b < 4; b++)
              if (be[b]) out_q[k][8*b +: 8] <= wdata_sh[8*b +: 8];
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign o_out_port[32*k +: 32] = out_q[k];
  end

endmodule

// File: tb/tb_lsu_mmio_ctrl.sv
// Directed and randomised bench for lsu_mmio_ctrl with a behavioural memory/port model.
module tb_lsu_mmio_ctrl;
  localparam int          DMEM_AW  = 8;
  localparam int          N_IN     = 2;
  localparam int          N_OUT    = 4;
  localparam logic [31:0] IN_BASE  = 32'h400;
  localparam logic [31:0] OUT_BASE = 32'h500;
  localparam int          MAX_WAIT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 0, load = 0, store = 0, sgn = 0, flush = 0, dmem_ack = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0, dmem_rdata = 0;
  logic [4:0] rd = 0;
  logic [32*N_IN-1:0] in_port = '0;
  logic req_ready, stall, wb_valid, wb_wren, exc_mis, exc_bus, dmem_req, dmem_we;
  logic [4:0] wb_rd;
  logic [31:0] wb_data, dmem_wdata;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [3:0] dmem_be;
  logic [32*N_OUT-1:0] out_port;
  logic [1:0] fsm_state;

  lsu_mmio_ctrl #(.DMEM_AW(DMEM_AW), .N_IN(N_IN), .N_OUT(N_OUT), .IN_BASE(IN_BASE),
                  .OUT_BASE(OUT_BASE), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_load(load), .i_store(store), .i_size(size), .i_signed(sgn), .i_addr(addr),
    .i_wdata(wdata), .i_rd_addr(rd), .i_flush(flush), .o_stall(stall),
    .o_wb_valid(wb_valid), .o_wb_wren(wb_wren), .o_wb_rd_addr(wb_rd), .o_wb_data(wb_data),
    .o_exc_misalign(exc_mis), .o_exc_bus(exc_bus), .o_dmem_req(dmem_req),
    .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_be(dmem_be),
    .o_dmem_wdata(dmem_wdata), .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
    .i_in_port(in_port), .o_out_port(out_port), .o_fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [256];  // responder storage, written with what the DUT presents
  logic [31:0] ref_mem [256];  // model view of memory, written from the access rules
  logic [31:0] ref_out [N_OUT];
  logic [31:0] in_val  [N_IN];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic s);
    logic [31:0] w, v;
    int idx;
    idx = int'(a[7:4]);
    if (a < 32'd1024) w = ref_mem[a[9:2]];
    else if ((a >> 8) == (IN_BASE >> 8) && idx < N_IN) w = in_val[idx];
    else if ((a >> 8) == (OUT_BASE >> 8) && idx < N_OUT) w = ref_out[idx];
    else w = 32'd0;
    v = w >> (8 * a[1:0]);
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (s && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (s && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One complete access: drive, serve memory, check response, update the model.
  task automatic access(input logic ld, input logic st, input logic [1:0] sz, input logic s,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                        input int ack_dly, input logic fl_acc, input logic fl_mem,
                        input string tag);
    logic eff_ld, mis, go_mem, ack_ok, bus_exp, flushed, done;
    logic [3:0] be;
    logic [31:0] wsh, exp_d;
    int nbytes, exp_req, req_n, stall_n, idx;
    eff_ld  = ld && !st;
    mis     = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
    go_mem  = (a < 32'd1024) && !mis && !(fl_acc && st);
    ack_ok  = ack_dly >= 0 && ack_dly < MAX_WAIT;
    bus_exp = go_mem && !ack_ok;
    flushed = fl_acc || (fl_mem && go_mem);
    exp_req = go_mem ? (ack_ok ? ack_dly + 1 : MAX_WAIT) : 0;
    nbytes  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    be      = 4'(((1 << nbytes) - 1) << a[1:0]);
    wsh     = wd << (8 * a[1:0]);
    exp_d   = exp_load(a, sz, s);
    @(negedge clk);
    chk({tag, ":ready"}, 32'(req_ready), 32'd1);
    req_valid = 1; load = ld; store = st; size = sz; sgn = s; addr = a; wdata = wd;
    rd = r; flush = fl_acc;
    @(negedge clk);
    req_valid = 0; load = 0; store = 0; flush = 0;
    req_n = 0; stall_n = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) stall_n++;
      dmem_ack = 0; flush = 0;
      if (dmem_req) begin
        req_n++;
        if (req_n == 1) begin
          chk({tag, ":dmem_addr"}, 32'(dmem_addr), 32'(a[9:2]));
          chk({tag, ":dmem_we"}, 32'(dmem_we), 32'(st));
          chk({tag, ":dmem_be"}, 32'(dmem_be), 32'(be));
          if (st) chk({tag, ":dmem_wdata"}, dmem_wdata, wsh);
          if (fl_mem) flush = 1;
        end
        if (req_n == ack_dly + 1) begin
          dmem_ack = 1;
          dmem_rdata = mem[dmem_addr];
          if (dmem_we) mem[dmem_addr] = merge(mem[dmem_addr], dmem_wdata, dmem_be);
        end
      end
      if (wb_valid) begin
        done = 1;
        chk({tag, ":misalign"}, 32'(exc_mis), 32'(mis));
        chk({tag, ":bus"}, 32'(exc_bus), 32'(bus_exp));
        chk({tag, ":wren"}, 32'(wb_wren), 32'(eff_ld && !mis && !bus_exp && !flushed));
        chk({tag, ":rd"}, 32'(wb_rd), 32'(r));
        if (eff_ld && !mis && !bus_exp) chk({tag, ":data"}, wb_data, exp_d);
      end
      if (!done) @(negedge clk);
    end
    dmem_ack = 0;
    if (!done) chk({tag, ":resp_timeout"}, 32'd0, 32'd1);
    chk({tag, ":req_cycles"}, 32'(req_n), 32'(exp_req));
    chk({tag, ":stall_cycles"}, 32'(stall_n), 32'(exp_req + 1));
    if (st && !mis && !fl_acc) begin
      idx = int'(a[7:4]);
      if (go_mem && ack_ok) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], wsh, be);
      if ((a >> 8) == (OUT_BASE >> 8) && idx < N_OUT) ref_out[idx] = merge(ref_out[idx], wsh, be);
    end
    @(negedge clk);
    chk({tag, ":ready_after"}, 32'(req_ready), 32'd1);
    for (int k = 0; k < N_OUT; k++) chk({tag, ":out_port"}, out_port[32*k +: 32], ref_out[k]);
  endtask

  task automatic set_in(input int k, input logic [31:0] v);
    in_port[32*k +: 32] = v;
    in_val[k] = v;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra, rw;
    logic [1:0] rsz;
    int kind, reg_sel, dly;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    for (int k = 0; k < N_OUT; k++) ref_out[k] = '0;
    for (int k = 0; k < N_IN; k++) in_val[k] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst:ready", 32'(req_ready), 32'd1);
    chk("rst:stall", 32'(stall), 32'd0);
    chk("rst:wb_valid", 32'(wb_valid), 32'd0);
    chk("rst:dmem_req", 32'(dmem_req), 32'd0);
    chk("rst:out_port0", out_port[31:0], 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Directed steps
    access(0, 1, 2'd2, 0, 32'h010, 32'hDEADBEEF, 5'd1, 3, 0, 0, "st_word");
    access(1, 0, 2'd0, 1, 32'h013, 32'h0, 5'd2, 1, 0, 0, "ld_byte_s");
    access(1, 0, 2'd0, 0, 32'h012, 32'h0, 5'd3, 0, 0, 0, "ld_byte_u");
    access(0, 1, 2'd1, 0, 32'h502, 32'h1234, 5'd4, 0, 0, 0, "st_half_out");
    access(1, 0, 2'd1, 0, 32'h502, 32'h0, 5'd5, 0, 0, 0, "ld_half_out");
    access(1, 0, 2'd2, 0, 32'h006, 32'h0, 5'd6, 0, 0, 0, "ld_misalign");
    access(0, 1, 2'd1, 0, 32'h511, 32'hFFFF, 5'd6, 0, 0, 0, "st_misalign_out");
    access(1, 0, 2'd2, 0, 32'h020, 32'h0, 5'd7, -1, 0, 0, "ld_timeout");
    access(1, 0, 2'd2, 0, 32'h010, 32'h0, 5'd8, 14, 0, 0, "ld_ack_at_limit");
    set_in(1, 32'hA5A5A5A5);
    access(1, 0, 2'd2, 0, 32'h410, 32'h0, 5'd9, 0, 0, 0, "ld_in1");
    access(1, 0, 2'd2, 0, 32'h420, 32'h0, 5'd10, 0, 0, 0, "ld_in_unmapped");
    access(0, 1, 2'd2, 0, 32'h800, 32'h11, 5'd10, 0, 0, 0, "st_unmapped");
    access(1, 0, 2'd2, 0, 32'h010, 32'h0, 5'd11, 2, 0, 1, "ld_flush_mem");
    access(0, 1, 2'd2, 0, 32'h010, 32'h0, 5'd12, 0, 1, 0, "st_flush_acc");
    access(0, 1, 2'd0, 0, 32'h021, 32'h77, 5'd12, 1, 0, 1, "st_flush_mem");
    access(1, 1, 2'd2, 0, 32'h030, 32'hCAFE0001, 5'd13, 0, 0, 0, "ld_st_both");
    access(1, 0, 2'd2, 0, 32'h030, 32'h0, 5'd14, 0, 0, 0, "ld_back");
    access(0, 1, 2'd0, 0, 32'h50F, 32'h9A, 5'd15, 0, 1, 0, "st_out_flush_acc");

    // Randomised accesses
    for (int n = 0; n < 60; n++) begin
      if (n % 15 == 0) set_in($urandom_range(0, N_IN - 1), $urandom);
      reg_sel = $urandom_range(0, 3);
      case (reg_sel)
        0: ra = 32'($urandom_range(0, 1023));
        1: ra = IN_BASE + 32'(16 * $urandom_range(0, N_IN)) + 32'($urandom_range(0, 15));
        2: ra = OUT_BASE + 32'(16 * $urandom_range(0, N_OUT)) + 32'($urandom_range(0, 15));
        default: ra = 32'h800 + 32'($urandom_range(0, 255));
      endcase
      rsz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) ra = (rsz == 2'd1) ? (ra & ~32'd1) : (rsz >= 2'd2) ? (ra & ~32'd3) : ra;
      rw = $urandom;
      kind = $urandom_range(0, 4);
      dly = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 4);
      access(kind <= 1 || kind == 4, kind >= 2, rsz, 1'($urandom_range(0, 1)), ra, rw,
             5'($urandom_range(0, 31)), dly, $urandom_range(0, 9) == 0,
             $urandom_range(0, 7) == 0, "rand");
    end

    // Asynchronous reset while waiting on memory
    @(negedge clk);
    req_valid = 1; load = 1; size = 2'd2; addr = 32'h040; rd = 5'd3;
    @(negedge clk);
    req_valid = 0; load = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_mem:req", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("rst_mem:req", 32'(dmem_req), 32'd0);
    chk("rst_mem:stall", 32'(stall), 32'd0);
    chk("rst_mem:wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mem:wren", 32'(wb_wren), 32'd0);
    chk("rst_mem:ready", 32'(req_ready), 32'd1);
    chk("rst_mem:out_port0", out_port[31:0], 32'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst:wb_valid", 32'(wb_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lsu_mmio_ctrl.md
Name: lsu_mmio_ctrl

Overview:
Parametrised load/store unit for the RV32IM MEM stage, replacing the fixed-map single-cycle LSU. It adds sub-word lane alignment, misalignment and bus-timeout detection, and a variable-latency data-memory handshake that stalls the pipeline. It also provides N-wide synchronised input ports and N-wide byte-maskable output ports. It sits between EX (effective address, store data) and the WB buffer.

Parameters:
DMEM_AW, 8, data-memory word-address width (DMEM size = 4*2^DMEM_AW bytes, base 0x000)
N_IN, 2, input ports at IN_BASE + 16*k, 1..16
N_OUT, 4, output ports at OUT_BASE + 16*k, 1..16
IN_BASE, 32'h400, input region base (256 B region)
OUT_BASE, 32'h500, output region base (256 B region)
MAX_WAIT, 15, cycles allowed for i_dmem_ack before bus error

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  EX presents an access
o_req_ready  out  1  LSU accepts (IDLE only)
i_load  in  1  load access
i_store  in  1  store access
i_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
i_signed  in  1  sign-extend sub-word load
i_addr  in  32  effective byte address
i_wdata  in  32  store data, right-aligned
i_rd_addr  in  5  destination register
i_flush  in  1  kill in-flight load writeback
o_stall  out  1  pipeline stall request
o_wb_valid  out  1  access completed (1-cycle pulse)
o_wb_wren  out  1  register-file write enable
o_wb_rd_addr  out  5  destination register
o_wb_data  out  32  aligned, extended load data
o_exc_misalign  out  1  qualifies o_wb_valid
o_exc_bus  out  1  qualifies o_wb_valid (timeout)
o_dmem_req  out  1  memory request, held until ack
o_dmem_we  out  1  write
o_dmem_addr  out  DMEM_AW  word address
o_dmem_be  out  4  byte enables
o_dmem_wdata  out  32  lane-aligned write data
i_dmem_ack  in  1  memory completion
i_dmem_rdata  in  32  read word, valid with ack
i_in_port  in  32*N_IN  asynchronous inputs
o_out_port  out  32*N_OUT  output port registers

Behaviour:
- Reset (async, i_rst_n=0): FSM=IDLE, all o_wb_*/o_exc_*/o_dmem_* = 0, o_stall=0, o_req_ready=1, output ports = 0, synchronisers = 0.
- Accept when i_req_valid & o_req_ready & (i_load | i_store). The request is registered into a hold package: addr, size, signed, rd, load/store, data.
- Region decode on the registered address:
  - DMEM when addr < 4*2^DMEM_AW.
  - IN when addr[31:8] == IN_BASE[31:8] and index addr[7:4] < N_IN.
  - OUT likewise against OUT_BASE and N_OUT.
  - Anything else is unmapped.
- Misaligned when half & addr[0], or word & addr[1:0] != 0. A misaligned access makes no memory or port access and completes in RESP with o_exc_misalign=1 and o_wb_wren=0.
- Lanes:
  - Base byte enables: byte=0001, half=0011, word=1111; shifted left by addr[1:0].
  - Write data: i_wdata shifted left by 8*addr[1:0], also applied to output port writes, which merge by byte enable.
  - Load data: shifted right by 8*addr[1:0], then zero- or sign-extended from bit 7 (byte) or bit 15 (half).
- FSM:
  - IDLE --accept, DMEM, aligned--> MEM. Otherwise an accepted request goes to RESP.
  - MEM: o_dmem_req=1, addr/we/be/wdata stable, wait counter increments. On i_dmem_ack: capture rdata, go to RESP. If the counter reaches MAX_WAIT without ack: drop req, go to RESP with o_exc_bus=1. An ack in that same cycle wins.
  - RESP: o_wb_valid=1 for one cycle; o_wb_wren = load & no exception & not flushed; back to IDLE.
  - o_stall = (state != IDLE); o_req_ready = (state == IDLE).
- Peripheral and unmapped accesses: accept->RESP gives 2-cycle latency. DMEM latency is 2 + ack wait.
  - IN read returns the 2-flop synchronised value. Stores to IN are ignored.
  - OUT read returns the register value. OUT registers update in the RESP cycle.
  - Unmapped load returns 0; unmapped store is a no-op with no exception.
- i_flush: sticky flag set by i_flush in MEM or RESP, or coinciding with accept. It clears in IDLE. While set, o_wb_wren=0 and OUT/DMEM stores are suppressed if the flush arrives before issue. A store already in MEM still completes.
- Reset mid-MEM aborts: req drops immediately, nothing is written back.
- i_load & i_store both 1 is treated as a store.

Test Plan:
- Store word 0xDEADBEEF at 0x010; ack after 3 cycles -> be=1111, stall held 5 cycles. Load byte signed at 0x013 -> o_wb_data=0xFFFFFFDE, wren=1.
- Store half 0x1234 at 0x502 (OUT port 0, prior value 0) -> o_out_port[31:0]=0x12340000. Load half unsigned 0x502 -> 0x00001234.
- Load word at 0x006 -> o_exc_misalign=1, wren=0, no o_dmem_req, 2-cycle latency.
- DMEM load, ack never arrives -> after MAX_WAIT=15 cycles o_exc_bus=1, req deasserts, o_req_ready returns next cycle.
- i_in_port[63:32] set to 0xA5A5A5A5, load word 0x410 two cycles later -> 0xA5A5A5A5. Load 0x420 with N_IN=2 -> 0.
- Load with i_flush in MEM -> o_wb_valid=1, wren=0. Assert i_rst_n=0 mid-MEM -> all outputs 0 asynchronously.
